// File: rtl/otp_decryptor.sv
// One-time-pad receive side: XORs paired ciphertext/key words and assembles
// NWORDS recovered words into one plaintext message offered on valid/ready.
module otp_decryptor #(
    parameter int KEY_SIZE = 16,
    parameter int MSG_SIZE = 240,
    localparam int NWORDS  = MSG_SIZE / KEY_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ct_valid,
    output logic                ct_ready,
    input  logic [KEY_SIZE-1:0] ct_data,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_SIZE-1:0] key_data,
    output logic                pt_valid,
    input  logic                pt_ready,
    output logic [MSG_SIZE-1:0] pt_data,
    output logic [3:0]          word_cnt
);

    // state      | meaning
    // ST_COLLECT | accepting joint ciphertext/key beats
    // ST_HOLD    | complete message offered on pt_data
    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    logic [0:0]          r_state;
    logic [MSG_SIZE-1:0] r_pt_data;
    logic [3:0]          r_word_cnt;
    logic                r_pt_valid;

    logic                w_collect;
    logic                w_beat;
    logic                w_last;
    logic [KEY_SIZE-1:0] w_word;

    // Each ready looks only at the other stream's valid, so the two streams
    // can never advance independently and no combinational loop is formed.
    assign w_collect = (r_state == ST_COLLECT);
    assign ct_ready  = w_collect && key_valid;
    assign key_ready = w_collect && ct_valid;
    assign w_beat    = w_collect && ct_valid && key_valid;
    assign w_last    = (r_word_cnt == 4'(NWORDS - 1));
    assign w_word    = ct_data ^ key_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_COLLECT;
            r_pt_data  <= '0;
            r_word_cnt <= '0;
            r_pt_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_beat) begin
                        for (int i = 0; i < NWORDS; i++) begin
                            if (r_word_cnt == 4'(i)) begin
                                r_pt_data[i*KEY_SIZE +: KEY_SIZE] <= w_word;
                            end
                        end
                        r_word_cnt <= r_word_cnt + 4'd1;
                        if (w_last) begin
                            r_state    <= ST_HOLD;
                            r_pt_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Old payload is left in place and overwritten word by word.
                    if (pt_ready) begin
                        r_state    <= ST_COLLECT;
                        r_pt_valid <= 1'b0;
                        r_word_cnt <= '0;
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

    assign pt_valid = r_pt_valid;
    assign pt_data  = r_pt_data;
    assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_otp_decryptor.sv
// Randomised and directed bench for otp_decryptor, checked every cycle against
// a message-level model plus literal expectations for each directed scenario.
module tb_otp_decryptor;
    localparam int KS = 16;
    localparam int MS = 240;
    localparam int NW = MS / KS;

    logic          clk = 1'b0;
    logic          rst;
    logic          ct_valid, key_valid, pt_ready;
    logic [KS-1:0] ct_data, key_data;
    logic          ct_ready, key_ready, pt_valid;
    logic [MS-1:0] pt_data;
    logic [3:0]    word_cnt;

    otp_decryptor #(.KEY_SIZE(KS), .MSG_SIZE(MS)) dut (
        .clk(clk), .rst(rst),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
        .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [MS-1:0] act, input logic [MS-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Message-level model: words received so far, and whether a message is held.
    int            m_cnt;
    bit            m_hold;
    logic [MS-1:0] m_pt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_hold = 0; m_pt = '0;
        end else if (m_hold) begin
            if (pt_ready) begin m_hold = 0; m_cnt = 0; end
        end else if (ct_valid && key_valid) begin
            m_pt[m_cnt*KS +: KS] = ct_data ^ key_data;
            m_cnt = m_cnt + 1;
            if (m_cnt == NW) m_hold = 1;
        end
    end

    always @(negedge clk) begin
        chk("cyc_pt_valid", MS'(pt_valid), MS'(m_hold));
        chk("cyc_word_cnt", MS'(word_cnt), MS'(m_cnt));
        chk("cyc_pt_data", pt_data, m_pt);
        chk("cyc_ct_ready", MS'(ct_ready), MS'(!m_hold && key_valid));
        chk("cyc_key_ready", MS'(key_ready), MS'(!m_hold && ct_valid));
    end

    int            rise_q[$];
    logic [MS-1:0] data_q[$];
    int            fall_cyc = -1;
    logic          prev_v = 1'b0;
    always @(negedge clk) begin
        if (pt_valid && !prev_v) begin
            rise_q.push_back(cyc);
            data_q.push_back(pt_data);
        end
        if (!pt_valid && prev_v) fall_cyc = cyc;
        prev_v = pt_valid;
    end

    int last_beat, first_beat;

    task automatic beat(input logic [KS-1:0] c, input logic [KS-1:0] k, input bit rnd);
        bit acc;
        int n;
        n = 0;
        ct_valid = 1; key_valid = 1; ct_data = c; key_data = k;
        do begin
            @(negedge clk);
            acc = ct_ready && key_ready;
            @(posedge clk); #1;
            if (rnd) pt_ready = 1'($urandom_range(0, 1));
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            tests++; fails++;
            $display("FAIL beat_timeout: got no accept expected accept within 200 cycles");
        end
        last_beat = cyc;
        ct_valid = 0; key_valid = 0;
    endtask

    task automatic send_msg(input logic [KS-1:0] ct[NW], input logic [KS-1:0] key[NW],
                            input int stall_at, input int stall_len, input bit rnd);
        for (int i = 0; i < NW; i++) begin
            if (i == stall_at) begin
                ct_valid = 1; key_valid = 0; ct_data = ct[i]; key_data = '0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_ct_ready", MS'(ct_ready), MS'(0));
                    chk("stall_word_cnt", MS'(word_cnt), MS'(stall_at));
                    @(posedge clk); #1;
                end
            end
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    ct_valid  = 1'($urandom_range(0, 1));
                    key_valid = ct_valid ? 1'b0 : 1'($urandom_range(0, 1));
                    ct_data   = KS'($urandom);
                    key_data  = KS'($urandom);
                    pt_ready  = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            beat(ct[i], key[i], rnd);
            if (i == 0) first_beat = last_beat;
        end
    endtask

    task automatic wait_rise(input int n);
        int t;
        t = 0;
        while (rise_q.size() < n && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (rise_q.size() < n) begin
            tests++; fails++;
            $display("FAIL rise_timeout: got %0d messages expected %0d", rise_q.size(), n);
        end
    endtask

    logic [KS-1:0] ct_a[NW], key_a[NW], pl_a[NW];
    logic [MS-1:0] exp_inc, exp_msg, held;
    logic [MS-1:0] exp_rnd[$];
    int            nr, r0;

    initial begin
        rst = 1; ct_valid = 0; key_valid = 0; ct_data = '0; key_data = '0; pt_ready = 1;
        for (int i = 0; i < NW; i++) exp_inc[i*KS +: KS] = KS'(i);
        repeat (2) @(negedge clk);
        chk("reset_pt_valid", MS'(pt_valid), MS'(0));
        chk("reset_word_cnt", MS'(word_cnt), MS'(0));
        chk("reset_pt_data", pt_data, '0);
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;

        // Basic decrypt: pt_valid rises on the edge of the 15th beat.
        for (int i = 0; i < NW; i++) begin ct_a[i] = 16'hA5A5 ^ KS'(i); key_a[i] = 16'hA5A5; end
        send_msg(ct_a, key_a, -1, 0, 0);
        wait_rise(1);
        chk("basic_latency", MS'(rise_q[0] - first_beat), MS'(NW - 1));
        chk("basic_pulse", MS'(pt_valid), MS'(0));
        chk("basic_data", data_q[0], exp_inc);

        // Key stall after word 5 delays completion by 3 cycles.
        send_msg(ct_a, key_a, 5, 3, 0);
        wait_rise(2);
        chk("stall_latency", MS'(rise_q[1] - first_beat), MS'(NW - 1 + 3));
        chk("stall_data", data_q[1], exp_inc);

        // Output backpressure.
        pt_ready = 0;
        for (int i = 0; i < NW; i++) begin
            ct_a[i] = KS'($urandom); key_a[i] = KS'($urandom);
            exp_msg[i*KS +: KS] = ct_a[i] ^ key_a[i];
        end
        send_msg(ct_a, key_a, -1, 0, 0);
        wait_rise(3);
        chk("bp_data", data_q[2], exp_msg);
        held = pt_data;
        repeat (10) begin
            ct_valid = 1; key_valid = 1;
            @(negedge clk);
            chk("bp_valid", MS'(pt_valid), MS'(1));
            chk("bp_stable", pt_data, held);
            chk("bp_ready", MS'({ct_ready, key_ready}), MS'(0));
            @(posedge clk); #1;
        end
        pt_ready = 1;
        for (int i = 0; i < NW; i++) begin ct_a[i] = 16'hA5A5 ^ KS'(i); key_a[i] = 16'hA5A5; end
        send_msg(ct_a, key_a, -1, 0, 0);
        chk("bp_restart", MS'(first_beat), MS'(fall_cyc + 1));
        wait_rise(4);
        chk("bp_next_data", data_q[3], exp_inc);

        // Reset mid-message.
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) beat(KS'($urandom), KS'($urandom), 0);
        nr = rise_q.size();
        ct_valid = 1; key_valid = 1;
        #2 rst = 1;
        #1;
        chk("rst_word_cnt", MS'(word_cnt), MS'(0));
        chk("rst_pt_valid", MS'(pt_valid), MS'(0));
        chk("rst_pt_data", pt_data, '0);
        chk("rst_ct_ready", MS'(ct_ready), MS'(1));
        ct_valid = 0; key_valid = 0;
        @(posedge clk); #1; rst = 0;
        send_msg(ct_a, key_a, -1, 0, 0);
        wait_rise(nr + 1);
        repeat (3) @(posedge clk); #1;
        chk("rst_msg_count", MS'(rise_q.size()), MS'(nr + 1));
        chk("rst_new_data", data_q[nr], exp_inc);

        // Round trip with key 1, 2, 3, ...
        for (int i = 0; i < NW; i++) begin
            pl_a[i]  = KS'($urandom);
            key_a[i] = KS'(i + 1);
            ct_a[i]  = pl_a[i] ^ key_a[i];
            exp_msg[i*KS +: KS] = pl_a[i];
        end
        nr = rise_q.size();
        send_msg(ct_a, key_a, -1, 0, 0);
        wait_rise(nr + 1);
        chk("roundtrip_data", data_q[nr], exp_msg);

        // Back-to-back messages.
        @(posedge clk); #1;
        nr = rise_q.size();
        for (int i = 0; i < NW; i++) begin ct_a[i] = 16'hA5A5 ^ KS'(i); key_a[i] = 16'hA5A5; end
        send_msg(ct_a, key_a, -1, 0, 0);
        send_msg(ct_a, key_a, -1, 0, 0);
        wait_rise(nr + 2);
        chk("b2b_spacing", MS'(rise_q[nr+1] - rise_q[nr]), MS'(NW + 1));
        chk("b2b_data0", data_q[nr], exp_inc);
        chk("b2b_data1", data_q[nr+1], exp_inc);

        // Random traffic with bubbles and random consumer backpressure.
        r0 = rise_q.size();
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < NW; i++) begin
                ct_a[i] = KS'($urandom); key_a[i] = KS'($urandom);
                exp_msg[i*KS +: KS] = ct_a[i] ^ key_a[i];
            end
            exp_rnd.push_back(exp_msg);
            send_msg(ct_a, key_a, -1, 0, 1);
        end
        pt_ready = 1;
        wait_rise(r0 + 4);
        for (int m = 0; m < 4; m++) chk("rnd_data", data_q[r0+m], exp_rnd[m]);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog");
    end
endmodule
